// File: rtl/cmp_pkg.sv
// Shared definitions for the sequential magnitude comparator: FSM state
// encodings and the one-hot {gt,eq,lt} result constants.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit order matches the {gt, eq, lt} result concatenation.
    localparam logic [2:0] CMP_LT = 3'b001;
    localparam logic [2:0] CMP_EQ = 3'b010;
    localparam logic [2:0] CMP_GT = 3'b100;

endpackage

// File: rtl/cmp_chunk.sv
// DIGIT-bit combinational magnitude comparator with cascade inputs/outputs;
// a decision already made by a more significant chunk is never overridden.
module cmp_chunk #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             gt_in,
    input  logic             eq_in,
    input  logic             lt_in,
    output logic             gt_out,
    output logic             eq_out,
    output logic             lt_out
);

    assign gt_out = gt_in | (eq_in & (a > b));
    assign lt_out = lt_in | (eq_in & (a < b));
    assign eq_out = eq_in & (a == b);

endmodule

// File: rtl/seq_mag_comparator.sv
// Multi-cycle WIDTH-bit magnitude comparator, DIGIT bits per cycle, MSB chunk
// first. Define SEQ_CMP_EARLY_EXIT_EN to stop scanning at the first differing chunk.
module seq_mag_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / DIGIT;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    state_t             state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [IDX_W-1:0]   idx;
    logic               g_q, e_q, l_q;
    logic [DIGIT-1:0]   chunk_a, chunk_b;
    logic               g_n, e_n, l_n;
    logic               last;
    logic [WIDTH-1:0]   msb_flip;

    // Flipping the sign bit of both operands maps two's-complement order onto unsigned order.
    assign msb_flip = WIDTH'(signed_mode) << (WIDTH - 1);

    always_comb begin
        chunk_a = DIGIT'(a_q >> (int'(idx) * DIGIT));
        chunk_b = DIGIT'(b_q >> (int'(idx) * DIGIT));
    end

`ifdef SEQ_CMP_EARLY_EXIT_EN
    assign last = (idx == '0) || !e_n;
`else
    assign last = (idx == '0);
`endif

    cmp_chunk #(.DIGIT(DIGIT)) u_chunk (
        .a      (chunk_a),
        .b      (chunk_b),
        .gt_in  (g_q),
        .eq_in  (e_q),
        .lt_in  (l_q),
        .gt_out (g_n),
        .eq_out (e_n),
        .lt_out (l_n)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            lt        <= 1'b0;
            eq        <= 1'b0;
            gt        <= 1'b0;
            busy      <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            idx       <= '0;
            g_q       <= 1'b0;
            e_q       <= 1'b0;
            l_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= a ^ msb_flip;
                        b_q      <= b ^ msb_flip;
                        idx      <= IDX_W'(NCHUNK - 1);
                        g_q      <= 1'b0;
                        e_q      <= 1'b1;
                        l_q      <= 1'b0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    g_q <= g_n;
                    e_q <= e_n;
                    l_q <= l_n;
                    if (last) begin
                        out_valid <= 1'b1;
                        gt        <= g_n;
                        eq        <= e_n;
                        lt        <= l_n;
                        state     <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        gt        <= 1'b0;
                        eq        <= 1'b0;
                        lt        <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Directed scoreboard bench for seq_mag_comparator (WIDTH=16, DIGIT=4); expected
// latency follows SEQ_CMP_EARLY_EXIT_EN when the bench is built with it.
module tb_seq_mag_comparator;
    import cmp_pkg::*;

    localparam int WIDTH  = 16;
    localparam int DIGIT  = 4;
    localparam int NCHUNK = WIDTH / DIGIT;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             out_valid;
    logic             out_ready;
    logic             lt, eq, gt;
    logic             busy;

    typedef struct {
        logic [2:0]  flags;
        int unsigned lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seq_mag_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .lt          (lt),
        .eq          (eq),
        .gt          (gt),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                                   input logic sm);
        exp_t        e;
        logic [WIDTH-1:0] diff;
        int unsigned k;
        bit          found;
        if (sm) begin
            if ($signed(xa) < $signed(xb))      e.flags = CMP_LT;
            else if ($signed(xa) > $signed(xb)) e.flags = CMP_GT;
            else                                e.flags = CMP_EQ;
        end else begin
            if (xa < xb)      e.flags = CMP_LT;
            else if (xa > xb) e.flags = CMP_GT;
            else              e.flags = CMP_EQ;
        end
        e.lat = NCHUNK;
`ifdef SEQ_CMP_EARLY_EXIT_EN
        diff  = xa ^ xb;
        found = 1'b0;
        k     = 0;
        for (int c = NCHUNK - 1; c >= 0; c--) begin
            if (!found && (((diff >> (c * DIGIT)) & 16'hF) != 0)) begin
                found = 1'b1;
                k     = c;
            end
        end
        if (found) e.lat = NCHUNK - k;
`else
        diff  = '0;
        found = 1'b0;
        k     = 0;
`endif
        return e;
    endfunction

    task automatic send(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb, input logic sm);
        int unsigned n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("accept_ready", in_ready, 1);
        a = xa; b = xb; signed_mode = sm; in_valid = 1'b1;
        sb.push_back(model(xa, xb, sm));
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); signed_mode = 1'($urandom);
    endtask

    task automatic collect(input string tag, input bit handshake);
        exp_t        e;
        int unsigned n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_valid"}, out_valid, 1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, sb.size(), 1);
        end else begin
            e = sb.pop_front();
            check({tag, "_latency"}, n, e.lat);
            check({tag, "_flags"}, {gt, eq, lt}, e.flags);
        end
        check({tag, "_busy"}, {busy, in_ready}, 2'b10);
        if (handshake) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check({tag, "_released"}, {out_valid, gt, eq, lt, in_ready, busy}, 6'b000010);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic             rs;
        bit               leaked;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; signed_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {in_ready, out_valid, lt, eq, gt, busy}, 6'b100000);
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(16'h1234, 16'h1234, 1'b0); collect("eq_1234", 1);
        send(16'h8000, 16'h7FFF, 1'b0); collect("gt_unsigned", 1);
        send(16'h8000, 16'h7FFF, 1'b1); collect("lt_signed", 1);
        send(16'h00F1, 16'h00F2, 1'b0); collect("lt_low_chunk", 1);
        send(16'hFFFF, 16'h0001, 1'b1); collect("neg1_lt_1", 1);
        send(16'hFFFF, 16'h0001, 1'b0); collect("ffff_gt_1", 1);

        // Backpressure: result must hold while new operands are offered.
        send(16'h0010, 16'h0020, 1'b0);
        collect("bp_result", 0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = 16'hFFFF; b = 16'h0000; signed_mode = 1'b0;
            @(posedge clk); #1;
            check("bp_hold", {out_valid, in_ready, gt, eq, lt}, {2'b10, CMP_LT});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release", {out_valid, in_ready, busy, gt, eq, lt}, 6'b010000);
        repeat (2) @(posedge clk);
        #1;
        check("bp_no_capture", {out_valid, busy}, 2'b00);
        send(16'h0300, 16'h0300, 1'b0); collect("after_bp", 1);

        // Reset during SCAN discards the pending result.
        a = 16'h1000; b = 16'h2000; signed_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("mid_scan_busy", {busy, in_ready}, 2'b10);
        rst_n = 1'b0;
        #1;
        check("async_reset", {in_ready, out_valid, lt, eq, gt, busy}, 6'b100000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        leaked = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || busy !== 1'b0) leaked = 1'b1;
        end
        check("reset_discard", leaked, 0);
        send(16'h0005, 16'h0003, 1'b0); collect("post_reset_gt", 1);

        for (int i = 0; i < 8; i++) begin
            ra = 16'($urandom);
            rb = (i % 2 == 0) ? (ra ^ (16'h1 << $urandom_range(15, 0))) : 16'($urandom);
            rs = 1'($urandom);
            send(ra, rb, rs); collect("random", 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
